// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory port arbiter and the pipeline control stages.
// State encodings, access op encodings and default bus widths.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF      = 16;
    localparam int unsigned DATA_W_DEF      = 16;
    localparam int unsigned WAIT_STATES_DEF = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_D_ACC  = 3'd1;
    localparam logic [2:0] ST_D_DONE = 3'd2;
    localparam logic [2:0] ST_F_ACC  = 3'd3;
    localparam logic [2:0] ST_F_DONE = 3'd4;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    // Counter width able to hold WAIT_STATES; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned wait_states);
        return (wait_states == 0) ? 1 : $clog2(wait_states + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data-access and external-memory signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipeline/memory.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_data;
    logic              if_valid;

    logic              mr;
    logic              mw;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic              hold;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rd;
    logic              mem_wr;
    logic              err;

    modport slave (
        input  if_req, if_addr, mr, mw, d_addr, d_wdata, mem_rdata,
        output if_data, if_valid, d_rdata, d_valid, hold,
               mem_addr, mem_wdata, mem_rd, mem_wr, err
    );

    modport master (
        output if_req, if_addr, mr, mw, d_addr, d_wdata, mem_rdata,
        input  if_data, if_valid, d_rdata, d_valid, hold,
               mem_addr, mem_wdata, mem_rd, mem_wr, err
    );

endinterface

// File: rtl/mem_port_arbiter_wait_counter.sv
// Loadable down-counter timing the wait states of one memory access.
// Saturates at zero; zero_c flags the final strobe cycle.
module mem_port_arbiter_wait_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero_c
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero_c) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port memory between instruction fetch and MEM-stage data access.
// Each access strobes memory for WAIT_STATES+1 cycles, then pulses a one-cycle valid.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned WAIT_STATES = WAIT_STATES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = cnt_width(WAIT_STATES);

    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic              data_req;
    logic              grant_d;
    logic              grant_f;
    logic              acc_done;
    logic              in_acc;
    logic              cnt_zero;

    logic              last_data_q;
    logic              op_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_rd_q;
    logic              mem_wr_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic [DATA_W-1:0] if_data_q;
    logic              d_valid_q;
    logic              if_valid_q;
    logic              err_q;

    assign data_req = bus.mr | bus.mw;
    assign in_acc   = (state_q == ST_D_ACC) || (state_q == ST_F_ACC);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and grant decisions; fetch wins a tie only right after a data grant
    always_comb begin
        state_d  = state_q;
        grant_d  = 1'b0;
        grant_f  = 1'b0;
        acc_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (data_req && !(bus.if_req && last_data_q)) begin
                    grant_d = 1'b1;
                    state_d = ST_D_ACC;
                end else if (bus.if_req) begin
                    grant_f = 1'b1;
                    state_d = ST_F_ACC;
                end
            end
            ST_D_ACC: begin
                if (cnt_zero) begin
                    acc_done = 1'b1;
                    state_d  = ST_D_DONE;
                end
            end
            ST_F_ACC: begin
                if (cnt_zero) begin
                    acc_done = 1'b1;
                    state_d  = ST_F_DONE;
                end
            end
            ST_D_DONE: state_d = ST_IDLE;
            ST_F_DONE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    mem_port_arbiter_wait_counter #(
        .WIDTH (CNT_W)
    ) u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (grant_d | grant_f),
        .load_val (CNT_W'(WAIT_STATES)),
        .dec      (in_acc),
        .zero_c   (cnt_zero)
    );

    // Access datapath: latch request on grant, capture read data on the last strobe edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_data_q <= 1'b0;
            op_q        <= OP_RD;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            d_rdata_q   <= '0;
            if_data_q   <= '0;
            d_valid_q   <= 1'b0;
            if_valid_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            d_valid_q  <= (state_d == ST_D_DONE);
            if_valid_q <= (state_d == ST_F_DONE);
            if (grant_d) begin
                mem_addr_q  <= bus.d_addr;
                mem_wdata_q <= bus.d_wdata;
                op_q        <= bus.mw ? OP_WR : OP_RD;
                mem_rd_q    <= !bus.mw;
                mem_wr_q    <= bus.mw;
                last_data_q <= 1'b1;
                if (bus.mr && bus.mw) begin
                    err_q <= 1'b1;
                end
            end else if (grant_f) begin
                mem_addr_q  <= bus.if_addr;
                op_q        <= OP_RD;
                mem_rd_q    <= 1'b1;
                mem_wr_q    <= 1'b0;
                last_data_q <= 1'b0;
            end
            if (acc_done) begin
                mem_rd_q <= 1'b0;
                mem_wr_q <= 1'b0;
                if (state_q == ST_D_ACC && op_q == OP_RD) begin
                    d_rdata_q <= bus.mem_rdata;
                end
                if (state_q == ST_F_ACC) begin
                    if_data_q <= bus.mem_rdata;
                end
            end
        end
    end

    // Stall drops in D_DONE so the pipeline advances exactly once per data access
    assign bus.hold      = data_req && (state_q != ST_D_DONE);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_data   = if_data_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter: directed timing scenarios plus randomized
// concurrent fetch/data traffic against a memory-array reference model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int W = 2;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
    } d_exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;
    int   strobe_run;

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    d_exp_t      exp_d[$];
    logic [15:0] exp_f[$];
    logic [15:0] exp_last_rd;
    logic        err_model;
    d_exp_t      de;
    logic [15:0] fe;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus0 ();

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // External memory models
    assign bus.mem_rdata  = mem[bus.mem_addr];
    assign bus0.mem_rdata = bus0.mem_addr ^ 16'h5A5A;
    always @(posedge clk) if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;

    function automatic void chk1(input string name, input logic act, input logic want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, want);
        end
    endfunction

    function automatic void chk16(input string name, input logic [15:0] act, input logic [15:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, want);
        end
    endfunction

    function automatic void push_d(input logic [15:0] rdata, input logic err);
        d_exp_t e;
        e.rdata = rdata;
        e.err   = err;
        exp_d.push_back(e);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: protocol rules every cycle, scoreboard pops on each valid pulse
    always @(negedge clk) begin
        if (rst) begin
            strobe_run = 0;
        end else begin
            chk1("hold_rule", bus.hold, (bus.mr || bus.mw) && !bus.d_valid);
            if (bus.mem_rd || bus.mem_wr) begin
                chk1("strobe_exclusive", bus.mem_rd && bus.mem_wr, 1'b0);
                strobe_run++;
            end else if (strobe_run != 0) begin
                checks++;
                if (strobe_run != W + 1) begin
                    failures++;
                    $display("FAIL strobe_length at %0t: got %0d cycles, expected %0d", $time, strobe_run, W + 1);
                end
                strobe_run = 0;
            end
            if (bus.d_valid) begin
                checks++;
                if (exp_d.size() == 0) begin
                    failures++;
                    $display("FAIL d_unexpected at %0t: D_VALID with no outstanding data access", $time);
                end else begin
                    de = exp_d.pop_front();
                    chk16("d_rdata", bus.d_rdata, de.rdata);
                    chk1("d_err", bus.err, de.err);
                end
            end
            if (bus.if_valid) begin
                checks++;
                if (exp_f.size() == 0) begin
                    failures++;
                    $display("FAIL f_unexpected at %0t: IF_VALID with no outstanding fetch", $time);
                end else begin
                    fe = exp_f.pop_front();
                    chk16("if_data", bus.if_data, fe);
                end
            end
        end
    end

    task automatic check_latency(input string name, input int lat);
        checks++;
        if (lat < W + 2 || lat > 2 * W + 5) begin
            failures++;
            $display("FAIL %s at %0t: got %0d cycles, allowed %0d..%0d", name, $time, lat, W + 2, 2 * W + 5);
        end
    endtask

    task automatic data_driver(input int count);
        for (int i = 0; i < count; i++) begin
            int          sel;
            int          n;
            int          t0;
            logic [15:0] addr;
            logic [15:0] wd;
            sel  = int'($urandom_range(0, 9));
            addr = 16'($urandom_range(0, 255));
            wd   = 16'($urandom);
            if (sel < 5) begin
                exp_last_rd = ref_mem[addr];
                push_d(exp_last_rd, err_model);
                bus.mr = 1'b1;
            end else begin
                ref_mem[addr] = wd;
                if (sel == 9) err_model = 1'b1;
                push_d(exp_last_rd, err_model);
                bus.mw = 1'b1;
                bus.mr = (sel == 9);
            end
            bus.d_addr  = addr;
            bus.d_wdata = wd;
            t0 = cyc;
            n  = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.d_valid && n < 40);
            chk1("d_handshake", bus.d_valid, 1'b1);
            check_latency("d_latency", cyc - t0);
            next_cycle();
            bus.mr      = 1'b0;
            bus.mw      = 1'b0;
            bus.d_addr  = 16'($urandom);
            bus.d_wdata = 16'($urandom);
            repeat ($urandom_range(0, 2)) next_cycle();
        end
    endtask

    task automatic fetch_driver(input int count);
        for (int i = 0; i < count; i++) begin
            int          n;
            int          t0;
            logic [15:0] addr;
            addr = 16'h8000 + 16'($urandom_range(0, 255));
            exp_f.push_back(ref_mem[addr]);
            bus.if_req  = 1'b1;
            bus.if_addr = addr;
            t0 = cyc;
            n  = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.if_valid && n < 40);
            chk1("f_handshake", bus.if_valid, 1'b1);
            check_latency("f_latency", cyc - t0);
            next_cycle();
            bus.if_req  = 1'b0;
            bus.if_addr = 16'($urandom);
            repeat ($urandom_range(0, 2)) next_cycle();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        checks      = 0;
        failures    = 0;
        strobe_run  = 0;
        cyc         = 0;
        exp_last_rd = 16'h0000;
        err_model   = 1'b0;
        rst         = 1'b1;
        bus.if_req  = 1'b0; bus.if_addr  = '0; bus.mr  = 1'b0; bus.mw  = 1'b0;
        bus.d_addr  = '0;   bus.d_wdata  = '0;
        bus0.if_req = 1'b0; bus0.if_addr = '0; bus0.mr = 1'b0; bus0.mw = 1'b0;
        bus0.d_addr = '0;   bus0.d_wdata = '0;
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 16'(i * 7) ^ 16'hC35A;
            ref_mem[i] = 16'(i * 7) ^ 16'hC35A;
        end
        mem[16'h0040]     = 16'hBEEF;
        ref_mem[16'h0040] = 16'hBEEF;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst_mem_rd", bus.mem_rd, 1'b0);
        chk1("rst_mem_wr", bus.mem_wr, 1'b0);
        chk1("rst_d_valid", bus.d_valid, 1'b0);
        chk1("rst_if_valid", bus.if_valid, 1'b0);
        chk1("rst_err", bus.err, 1'b0);
        chk1("rst_hold", bus.hold, 1'b0);
        chk16("rst_d_rdata", bus.d_rdata, 16'h0000);
        chk16("rst_if_data", bus.if_data, 16'h0000);
        chk16("rst_mem_addr", bus.mem_addr, 16'h0000);
        chk16("rst_mem_wdata", bus.mem_wdata, 16'h0000);
        next_cycle();
        rst = 1'b0;

        // Zero wait states: one strobe cycle, valid two cycles after the request
        next_cycle();
        bus0.mr     = 1'b1;
        bus0.d_addr = 16'h0033;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            chk1("w0_mem_rd", bus0.mem_rd, c == 1);
            chk1("w0_d_valid", bus0.d_valid, c == 2);
            chk1("w0_hold", bus0.hold, c <= 1);
            if (c == 2) chk16("w0_d_rdata", bus0.d_rdata, 16'h5A69);
            next_cycle();
            if (c == 2) bus0.mr = 1'b0;
        end

        // Contention straight after reset: data, fetch, data
        exp_last_rd = 16'hBEEF;
        push_d(16'hBEEF, 1'b0);
        exp_f.push_back(ref_mem[16'h8004]);
        push_d(16'hBEEF, 1'b0);
        bus.mr      = 1'b1;
        bus.d_addr  = 16'h0040;
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h8004;
        for (int c = 0; c <= 15; c++) begin
            @(negedge clk);
            chk1("ct_d_valid", bus.d_valid, c == 4 || c == 14);
            chk1("ct_if_valid", bus.if_valid, c == 9);
            chk1("ct_hold", bus.hold, !(c == 4 || c >= 14));
            next_cycle();
            if (c == 14) begin
                bus.mr     = 1'b0;
                bus.if_req = 1'b0;
            end
        end

        // Data read with address changed after the grant edge
        push_d(16'hBEEF, 1'b0);
        bus.mr     = 1'b1;
        bus.d_addr = 16'h0040;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            chk1("rd_mem_rd", bus.mem_rd, c >= 1 && c <= 3);
            chk1("rd_hold", bus.hold, c <= 3);
            chk1("rd_d_valid", bus.d_valid, c == 4);
            if (c == 2) chk16("rd_mem_addr", bus.mem_addr, 16'h0040);
            next_cycle();
            if (c == 0) bus.d_addr = 16'h1111;
            if (c == 4) bus.mr = 1'b0;
        end

        // Write: D_RDATA keeps the last read word
        push_d(exp_last_rd, 1'b0);
        ref_mem[16'h0010] = 16'h1234;
        bus.mw      = 1'b1;
        bus.d_addr  = 16'h0010;
        bus.d_wdata = 16'h1234;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            chk1("wr_mem_wr", bus.mem_wr, c >= 1 && c <= 3);
            chk1("wr_mem_rd", bus.mem_rd, 1'b0);
            chk1("wr_d_valid", bus.d_valid, c == 4);
            chk1("wr_err", bus.err, 1'b0);
            if (c >= 1 && c <= 3) begin
                chk16("wr_mem_wdata", bus.mem_wdata, 16'h1234);
                chk16("wr_mem_addr", bus.mem_addr, 16'h0010);
            end
            next_cycle();
            if (c == 0) bus.d_wdata = 16'hDEAD;
            if (c == 4) bus.mw = 1'b0;
        end

        // Data request arriving during a fetch waits for the fetch to finish
        exp_f.push_back(ref_mem[16'h8010]);
        exp_last_rd = 16'h1234;
        push_d(16'h1234, 1'b0);
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h8010;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            chk1("df_hold", bus.hold, c >= 1 && c <= 8);
            chk1("df_if_valid", bus.if_valid, c == 4);
            chk1("df_d_valid", bus.d_valid, c == 9);
            next_cycle();
            if (c == 0) begin
                bus.mr     = 1'b1;
                bus.d_addr = 16'h0010;
            end
            if (c == 4) bus.if_req = 1'b0;
            if (c == 9) bus.mr = 1'b0;
        end

        // MR and MW together: write wins and ERR latches
        ref_mem[16'h0020] = 16'h0BAD;
        err_model = 1'b1;
        push_d(exp_last_rd, 1'b1);
        bus.mr      = 1'b1;
        bus.mw      = 1'b1;
        bus.d_addr  = 16'h0020;
        bus.d_wdata = 16'h0BAD;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            chk1("er_mem_wr", bus.mem_wr, c >= 1 && c <= 3);
            chk1("er_mem_rd", bus.mem_rd, 1'b0);
            chk1("er_d_valid", bus.d_valid, c == 4);
            if (c >= 1) chk1("er_err", bus.err, 1'b1);
            next_cycle();
            if (c == 4) begin
                bus.mr = 1'b0;
                bus.mw = 1'b0;
            end
        end
        repeat (3) next_cycle();
        @(negedge clk);
        chk1("er_err_sticky", bus.err, 1'b1);

        // Reset in the middle of a read abandons it
        next_cycle();
        bus.mr     = 1'b1;
        bus.d_addr = 16'h0040;
        next_cycle();
        next_cycle();
        #2;
        chk1("rs_mem_rd_before", bus.mem_rd, 1'b1);
        rst = 1'b1;
        #1;
        chk1("rs_mem_rd", bus.mem_rd, 1'b0);
        chk1("rs_err", bus.err, 1'b0);
        bus.mr = 1'b0;
        exp_last_rd = 16'h0000;
        err_model   = 1'b0;
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk1("rs_no_valid", bus.d_valid, 1'b0);
            chk1("rs_err_clear", bus.err, 1'b0);
            next_cycle();
        end
        chk16("rs_d_rdata", bus.d_rdata, 16'h0000);

        // Randomized concurrent traffic
        fork
            data_driver(40);
            fetch_driver(40);
        join
        repeat (10) next_cycle();
        checks++;
        if (exp_d.size() != 0 || exp_f.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: %0d data and %0d fetch responses missing", exp_d.size(), exp_f.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port program/data memory between instruction fetch and the MEM-stage data access (MR/MW).
- Sequences each access over a fixed number of wait states, returns read data with a one-cycle valid pulse, and drives HOLD into the pipeline control stages while a data access is outstanding.
- Sits between the IF stage, the MEM-stage control (MR_OUT/MW_OUT), and the external memory.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 16, memory data width.
- WAIT_STATES, 2, extra cycles per access; each access drives the memory for WAIT_STATES+1 cycles. Legal range 0..15.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous reset, active-high.
- IF_REQ  in  1  fetch request, level.
- IF_ADDR  in  ADDR_W  fetch address.
- IF_DATA  out  DATA_W  fetched word, registered.
- IF_VALID  out  1  one-cycle pulse; IF_DATA is valid.
- MR_IN  in  1  data read request, level.
- MW_IN  in  1  data write request, level.
- D_ADDR  in  ADDR_W  data address.
- D_WDATA  in  DATA_W  write data.
- D_RDATA  out  DATA_W  read word, registered.
- D_VALID  out  1  one-cycle pulse; data access complete.
- HOLD  out  1  stall request to pipeline control.
- MEM_ADDR  out  ADDR_W  memory address, registered.
- MEM_WDATA  out  DATA_W  memory write data, registered.
- MEM_RDATA  in  DATA_W  memory read data.
- MEM_RD  out  1  memory read strobe.
- MEM_WR  out  1  memory write strobe.
- ERR  out  1  sticky; set when MR_IN and MW_IN are both high.

Behaviour:
- Reset values: state IDLE; counter 0; last_data 0; all registered outputs 0; MEM_RD/MEM_WR drop immediately on RESET.
- States: IDLE, D_ACC, D_DONE, F_ACC, F_DONE.
- Grant (IDLE only):
  - data_req = MR_IN|MW_IN.
  - data_req alone -> D_ACC.
  - IF_REQ alone -> F_ACC.
  - Both requests -> F_ACC if last_data=1, else D_ACC. This alternation prevents fetch starvation.
- On grant edge:
  - latch address and write data into MEM_ADDR/MEM_WDATA;
  - latch op: MW_IN wins if both MR_IN and MW_IN are high, and ERR sets;
  - counter <= WAIT_STATES;
  - last_data <= 1 for a data grant, 0 for a fetch grant.
- *_ACC:
  - MEM_RD or MEM_WR high; fetch is always a read;
  - counter decrements each cycle;
  - on the edge where counter==0, capture MEM_RDATA into D_RDATA or IF_DATA (reads only) and go to the matching *_DONE.
- *_DONE: lasts one cycle; D_VALID/IF_VALID=1; strobes low; no grant taken; returns to IDLE.
- Latency:
  - request seen in IDLE at cycle 0 -> strobe high cycles 1..WAIT_STATES+1 -> valid at cycle WAIT_STATES+2;
  - a data request arriving during F_ACC waits for F_DONE and IDLE.
- HOLD = data_req & (state != D_DONE), combinational. It drops in the D_DONE cycle so the pipeline advances exactly once; the request seen during D_DONE belongs to the completed instruction and is ignored.
- Requests dropped mid-access: the access still completes and the valid pulse is still issued (writes are not abortable).
- Writes: D_RDATA is unchanged; D_VALID still pulses.
- Address/data inputs are ignored after the grant edge.
- RESET mid-access: the access is abandoned, no valid pulse, state returns to IDLE; ERR clears only on RESET.

Decomposition:
- Shared package holds:
  - the state enum (IDLE/D_ACC/D_DONE/F_ACC/F_DONE);
  - an op constant (OP_RD/OP_WR);
  - the default widths shared with the pipeline control stages.
- One natural sub-module: wait_counter, a loadable down-counter with a zero flag, width clog2(WAIT_STATES+1).

Test Plan (WAIT_STATES=2 unless noted):
- Data read only: MR_IN=1, D_ADDR=0x0040 at cycle 0, MEM_RDATA=0xBEEF at cycle 3 -> MEM_RD=1 cycles 1–3, MEM_ADDR=0x0040, D_VALID=1 and D_RDATA=0xBEEF at cycle 4; HOLD=1 cycles 0–3, 0 at cycle 4.
- Write: MW_IN=1, D_ADDR=0x0010, D_WDATA=0x1234 -> MEM_WR=1 cycles 1–3 with MEM_WDATA=0x1234; D_VALID at cycle 4; D_RDATA unchanged; ERR=0.
- Contention: IF_REQ and MR_IN held high from cycle 0 -> data granted first (valid cycle 4), fetch next (IF_VALID cycle 9); a further data request then precedes the next fetch.
- Data during fetch: IF_REQ at cycle 0, MR_IN at cycle 1 -> HOLD=1 cycles 1–8, fetch valid at cycle 4, data valid at cycle 9.
- Error and RESET: MR_IN=MW_IN=1 -> MEM_WR used, ERR=1 sticky. RESET pulsed at cycle 2 of an access -> MEM_RD=0 immediately, no D_VALID, ERR=0.
- WAIT_STATES=0: MR_IN at cycle 0 -> MEM_RD for 1 cycle (cycle 1), D_VALID at cycle 2.
